// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcode/funct
// encodings, ALU operation codes, the controller state encoding and the
// bundle of control signals driven each cycle.
package mips_pkg;

    // Instruction opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type function codes, IR[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0000;

    // Controller states; encodings are visible on state_o for debug
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    // All datapath controls in one bundle so a state can start from all-zero
    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ct;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// R-type function decoder: maps funct to the ALU operation code and flags
// whether the function is one this core implements.
module mc_alu_dec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ct,
    output logic       legal
);

    // Decode funct; unsupported codes yield alu_ct=0 and legal=0
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        alu_ct = 4'b0000;
        legal  = 1'b1;
        case (funct)
            FN_ADD:  alu_ct = ALU_ADD;
            FN_SUB:  alu_ct = ALU_SUB;
            FN_SLT:  alu_ct = ALU_SLT;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing the shared ALU,
// memory port, IR, PC and register file through fetch/decode/execute/
// memory/writeback. WAIT_MEM=1 stalls memory states on mem_ready.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN -- when defined, an
// illegal opcode or funct parks the FSM in TRAP with illegal_op=1 until
// reset; otherwise the instruction is dropped as a NOP.
module mc_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_MEM = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ct,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state_o
);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
    localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

    state_t     state;
    state_t     next_state;
    ctrl_t      ctrl;
    logic [3:0] dec_alu_ct;
    logic       dec_legal;
    logic       mem_done;

    mc_alu_dec u_alu_dec (
        .funct  (funct),
        .alu_ct (dec_alu_ct),
        .legal  (dec_legal)
    );

    // A memory access completes on mem_ready, or every cycle when not waiting
    assign mem_done = (WAIT_MEM == 0) || mem_ready;

    // State register; reset forces IDLE so every strobe drops at once
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Next-state and Moore outputs; unused encodings fall to FETCH with outputs 0
    always_comb begin
        ctrl       = '0;
        next_state = S_FETCH;
        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_ct    = ALU_ADD;
                if (mem_done) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_en    = 1'b1;
                    next_state    = S_DECODE;
                end else begin
                    next_state    = S_FETCH;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_ct    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default:      next_state = ILLEGAL_NEXT;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_ct    = ALU_ADD;
                next_state     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
                next_state    = mem_done ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                next_state     = mem_done ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_ct    = dec_alu_ct;
                next_state     = dec_legal ? S_ALUWB : ILLEGAL_NEXT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_ct    = ALU_SUB;
                ctrl.pc_src    = 2'b01;
                ctrl.pc_en     = alu_zero;
            end
            S_JUMP: begin
                ctrl.pc_src = 2'b10;
                ctrl.pc_en  = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_ct    = ALU_ADD;
                next_state     = S_ADDIWB;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
                next_state      = S_TRAP;
            end
`endif
            default: next_state = S_FETCH;
        endcase
    end

    assign pc_en      = ctrl.pc_en;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_ct     = ctrl.alu_ct;
    assign pc_src     = ctrl.pc_src;
    assign illegal_op = ctrl.illegal_op;
    assign state_o    = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: walks each instruction class through the
// FSM and compares state and control outputs against hand-derived values.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ct;
    logic [1:0] pc_src;
    logic       illegal_op;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    mc_ctrl #(.WAIT_MEM(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ct     (alu_ct),
        .pc_src     (pc_src),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [19:0] all_out;
        rst = 1'b0; opcode = 6'd0; funct = 6'd0; alu_zero = 1'b0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        all_out = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                   reg_write, alu_src_a, alu_src_b, alu_ct, pc_src, illegal_op};
        n_checks++;
        if (state_o !== 4'd0 || all_out !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_idle: state=%0d outputs=%h, want state=0 outputs=0", state_o, all_out);
        end
        tick();
        n_checks++;
        if (state_o !== 4'd1 || mem_read !== 1'b1 || alu_ct !== 4'b0010 || ir_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fetch: state=%0d mem_read=%b alu_ct=%b ir_write=%b, want 1/1/0010/0",
                     state_o, mem_read, alu_ct, ir_write);
        end
    endtask

    task automatic test_lw;
        opcode = 6'b100011; mem_ready = 1'b1;
        #1;
        n_checks++;
        if (state_o !== 4'd1 || ir_write !== 1'b1 || pc_en !== 1'b1 || alu_src_b !== 2'b01) begin
            n_fail++;
            $display("FAIL lw_fetch: state=%0d ir_write=%b pc_en=%b srcb=%b, want 1/1/1/01",
                     state_o, ir_write, pc_en, alu_src_b);
        end
        tick();
        n_checks++;
        if (state_o !== 4'd2 || alu_src_b !== 2'b11 || alu_src_a !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_decode: state=%0d srcb=%b srca=%b, want 2/11/0", state_o, alu_src_b, alu_src_a);
        end
        mem_ready = 1'b0;
        tick();
        n_checks++;
        if (state_o !== 4'd3 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_ct !== 4'b0010) begin
            n_fail++;
            $display("FAIL lw_memadr: state=%0d srca=%b srcb=%b alu_ct=%b, want 3/1/10/0010",
                     state_o, alu_src_a, alu_src_b, alu_ct);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (state_o !== 4'd4 || mem_read !== 1'b1 || iord !== 1'b1 || reg_write !== 1'b0) begin
                n_fail++;
                $display("FAIL lw_memrd_%0d: state=%0d mem_read=%b iord=%b reg_write=%b, want 4/1/1/0",
                         i, state_o, mem_read, iord, reg_write);
            end
        end
        mem_ready = 1'b1;
        tick();
        n_checks++;
        if (state_o !== 4'd5 || reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0 ||
            mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_memwb: state=%0d reg_write=%b mem_to_reg=%b reg_dst=%b mem_read=%b, want 5/1/1/0/0",
                     state_o, reg_write, mem_to_reg, reg_dst, mem_read);
        end
        tick();
        n_checks++;
        if (state_o !== 4'd1 || reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_return: state=%0d reg_write=%b, want 1/0", state_o, reg_write);
        end
    endtask

    task automatic test_rtype_sub;
        opcode = 6'b000000; funct = 6'b100010; mem_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (state_o !== 4'd7 || alu_ct !== 4'b0110 || alu_src_b !== 2'b00 || alu_src_a !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_exec: state=%0d alu_ct=%b srcb=%b srca=%b, want 7/0110/00/1",
                     state_o, alu_ct, alu_src_b, alu_src_a);
        end
        tick();
        n_checks++;
        if (state_o !== 4'd8 || reg_dst !== 1'b1 || reg_write !== 1'b1 || mem_to_reg !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_aluwb: state=%0d reg_dst=%b reg_write=%b mem_to_reg=%b, want 8/1/1/0",
                     state_o, reg_dst, reg_write, mem_to_reg);
        end
        tick();
        n_checks++;
        if (state_o !== 4'd1) begin
            n_fail++;
            $display("FAIL sub_return: state=%0d, want 1", state_o);
        end
    endtask

    task automatic test_beq;
        opcode = 6'b000100; alu_zero = 1'b1;
        tick();
        tick();
        n_checks++;
        if (state_o !== 4'd9 || pc_en !== 1'b1 || pc_src !== 2'b01 || alu_ct !== 4'b0110) begin
            n_fail++;
            $display("FAIL beq_taken: state=%0d pc_en=%b pc_src=%b alu_ct=%b, want 9/1/01/0110",
                     state_o, pc_en, pc_src, alu_ct);
        end
        tick();
        alu_zero = 1'b0;
        tick();
        tick();
        n_checks++;
        if (state_o !== 4'd9 || pc_en !== 1'b0 || pc_src !== 2'b01) begin
            n_fail++;
            $display("FAIL beq_not_taken: state=%0d pc_en=%b pc_src=%b, want 9/0/01", state_o, pc_en, pc_src);
        end
        tick();
        n_checks++;
        if (state_o !== 4'd1) begin
            n_fail++;
            $display("FAIL beq_return: state=%0d, want 1", state_o);
        end
    endtask

    task automatic test_jump_addi;
        opcode = 6'b000010;
        tick();
        tick();
        n_checks++;
        if (state_o !== 4'd10 || pc_en !== 1'b1 || pc_src !== 2'b10) begin
            n_fail++;
            $display("FAIL jump: state=%0d pc_en=%b pc_src=%b, want 10/1/10", state_o, pc_en, pc_src);
        end
        tick();
        opcode = 6'b001000;
        tick();
        tick();
        n_checks++;
        if (state_o !== 4'd11 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_ct !== 4'b0010) begin
            n_fail++;
            $display("FAIL addi_ex: state=%0d srca=%b srcb=%b alu_ct=%b, want 11/1/10/0010",
                     state_o, alu_src_a, alu_src_b, alu_ct);
        end
        tick();
        n_checks++;
        if (state_o !== 4'd12 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_wb: state=%0d reg_write=%b reg_dst=%b mem_to_reg=%b, want 12/1/0/0",
                     state_o, reg_write, reg_dst, mem_to_reg);
        end
        tick();
    endtask

    task automatic test_reset_mid_write;
        opcode = 6'b101011; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (state_o !== 4'd6 || mem_write !== 1'b1 || iord !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_memwr: state=%0d mem_write=%b iord=%b, want 6/1/1", state_o, mem_write, iord);
        end
        tick();
        n_checks++;
        if (state_o !== 4'd6 || mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_hold: state=%0d mem_write=%b, want 6/1", state_o, mem_write);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 4'd0 || mem_write !== 1'b0 || iord !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d mem_write=%b iord=%b, want 0/0/0", state_o, mem_write, iord);
        end
        tick();
        rst = 1'b1; mem_ready = 1'b1;
        tick();
        n_checks++;
        if (state_o !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_recover: state=%0d, want 1", state_o);
        end
    endtask

    task automatic test_illegal;
        opcode = 6'b111111; mem_ready = 1'b1;
        tick();
        tick();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (state_o !== 4'd13 || illegal_op !== 1'b1 || mem_read !== 1'b0 || pc_en !== 1'b0) begin
                n_fail++;
                $display("FAIL trap_%0d: state=%0d illegal_op=%b mem_read=%b pc_en=%b, want 13/1/0/0",
                         i, state_o, illegal_op, mem_read, pc_en);
            end
            tick();
        end
`else
        n_checks++;
        if (state_o !== 4'd1 || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_opcode_nop: state=%0d illegal_op=%b, want 1/0", state_o, illegal_op);
        end
        opcode = 6'b000000; funct = 6'b111111;
        tick();
        tick();
        n_checks++;
        if (state_o !== 4'd7 || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_funct_exec: state=%0d illegal_op=%b, want 7/0", state_o, illegal_op);
        end
        tick();
        n_checks++;
        if (state_o !== 4'd1 || reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_funct_nop: state=%0d reg_write=%b, want 1/0", state_o, reg_write);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype_sub();
        test_beq();
        test_jump_addi();
        test_reset_mid_write();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS core: a Moore FSM that sequences the shared 32-bit ALU, memory port, IR, PC and register file across FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives the ALU's 4-bit operation code: 0010 add, 0110 sub, 0000 set-less-than.
- Samples the ALU zero flag for beq.
- Stalls on a memory ready handshake.

Parameters:
- WAIT_MEM, 1, when 1 the FETCH/MEMRD/MEMWR states hold until mem_ready=1; when 0 mem_ready is ignored and those states last one cycle.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26].
- funct  input  6  IR[5:0].
- alu_zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access complete this cycle.
- pc_en  output  1  PC load enable, already qualified by branch and zero.
- iord  output  1  0 = memory address from PC, 1 = from ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR load enable.
- reg_dst  output  1  1 = rd, 0 = rt.
- mem_to_reg  output  1  1 = MDR, 0 = ALUOut.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  0 = PC, 1 = rs.
- alu_src_b  output  2  00 rt, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- alu_ct  output  4  ALU operation code.
- pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- illegal_op  output  1  decoded opcode/funct unsupported (see Optional Feature).
- state_o  output  4  current state encoding, for debug.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, TRAP=13.
- State register: resets asynchronously to IDLE when rst=0. All outputs are combinational from the state only (Moore), except pc_en in BRANCH, which also uses alu_zero. In IDLE every output is 0.
- IDLE -> FETCH unconditionally on the first clock after reset deasserts.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_ct=0010, pc_src=00. When the fetch completes (mem_ready=1, or always when WAIT_MEM=0), assert ir_write=1 and pc_en=1 and go to DECODE; otherwise stay in FETCH with ir_write=0 and pc_en=0.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ct=0010 to compute the branch target. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDIEX
  - anything else -> illegal handling
- MEMADR: alu_src_a=1, alu_src_b=10, alu_ct=0010. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Holds until mem_ready (when WAIT_MEM=1), then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEMWR: iord=1, mem_write=1. Holds until mem_ready (when WAIT_MEM=1), then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. alu_ct by funct: 100000 -> 0010, 100010 -> 0110, 101010 -> 0000. Any other funct -> illegal handling. Legal funct -> ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ct=0110, pc_src=01, pc_en=alu_zero (same cycle), then FETCH.
- JUMP: pc_src=10, pc_en=1, then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_ct=0010, then ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
- Unspecified outputs in any state are 0.
- Memory strobes are held stable for the whole wait period. mem_ready arriving in a non-memory state is ignored.
- Reset asserted mid-instruction: the FSM goes to IDLE immediately and all strobes drop asynchronously, so no partial register or memory write.
- Unused encodings 14–15 recover to FETCH on the next clock with all outputs 0.
- Latencies with mem_ready=1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode (in DECODE) or illegal funct (in EXEC) moves to TRAP. TRAP asserts illegal_op=1, keeps all other outputs 0, and stays there until reset.
- Undefined: the illegal case returns to FETCH, so the instruction executes as a NOP; illegal_op is tied to 0 and the TRAP state is unreachable (an encoding of 13 recovers like 14–15).

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - funct localparams: FN_ADD, FN_SUB, FN_SLT
  - ALU code localparams: ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0000
  - the state enum
- One natural sub-module: mc_alu_dec, a combinational funct-to-alu_ct decoder with a legal flag, instantiated by mc_ctrl.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> state_o=0 and all outputs 0; one cycle later state_o=1 with mem_read=1 and alu_ct=0010.
- lw (opcode 100011) with mem_ready delayed 2 cycles in MEMRD -> state sequence 1,2,3,4,4,4,5,1; reg_write=1 only in state 5 with mem_to_reg=1 and reg_dst=0.
- R-type sub (funct 100010) -> EXEC drives alu_ct=0110 and alu_src_b=00; ALUWB has reg_dst=1 and reg_write=1; returns to FETCH after 4 cycles.
- beq with alu_zero=1, then a second beq with alu_zero=0 -> pc_en=1 and pc_src=01 in the first BRANCH cycle; pc_en=0 in the second.
- Opcode 111111 -> with MC_CTRL_ILLEGAL_TRAP_EN, state_o=13 and illegal_op=1 held for 10 cycles; without it, state returns to 1 and illegal_op stays 0.
- Assert rst=0 while in MEMWR with mem_write=1 -> mem_write drops to 0 before the next clock edge and state_o=0.
